trigger_activity_stretcher: RTL

// Converts raw trigger activity (crossbar inputs and outputs) into front-panel LED indications.

---
 rtl/trigger_activity_stretcher.sv | 119 +++++++++++
 1 files changed

// File: rtl/trigger_activity_stretcher.sv
// Turns raw trigger activity into stretched front-panel LED indications and
// offers a new LED snapshot over valid/ready whenever the LED vector changes.
module trigger_activity_stretcher #(
  parameter int unsigned NUM_CHANNELS = 24,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PRESCALE     = 250000,
  parameter int unsigned HOLD_TICKS   = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] trig_raw,
  output logic [NUM_CHANNELS-1:0] led_out,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [NUM_CHANNELS-1:0] upd_leds
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned CW = $clog2(HOLD_TICKS + 1);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] prev_q, prev_d;
  logic [NUM_CHANNELS-1:0] toggle;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick;
  logic [CW-1:0]           hold_q [NUM_CHANNELS];
  logic [CW-1:0]           hold_d [NUM_CHANNELS];
  state_t                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] upd_leds_q, upd_leds_d;
  logic [NUM_CHANNELS-1:0] last_sent_q, last_sent_d;

  always_comb begin
    sync_d[0] = trig_raw;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    toggle = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  always_comb begin
    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // A toggle reload takes priority over a coincident tick decrement.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (toggle[i]) begin
        hold_d[i] = CW'(HOLD_TICKS);
      end else if (tick && (hold_q[i] != '0)) begin
        hold_d[i] = hold_q[i] - CW'(1);
      end else begin
        hold_d[i] = hold_q[i];
      end
      led_out[i] = (hold_q[i] != '0);
    end
  end

  // LED changes while PEND are not queued; IDLE re-compares the live vector.
  always_comb begin
    state_d     = state_q;
    upd_leds_d  = upd_leds_q;
    last_sent_d = last_sent_q;
    case (state_q)
      IDLE: begin
        if (led_out != last_sent_q) begin
          upd_leds_d = led_out;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (upd_ready) begin
          last_sent_d = upd_leds_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        hold_q[i] <= '0;
      end
      prev_q      <= '0;
      presc_q     <= '0;
      state_q     <= IDLE;
      upd_leds_q  <= '0;
      last_sent_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        hold_q[i] <= hold_d[i];
      end
      prev_q      <= prev_d;
      presc_q     <= presc_d;
      state_q     <= state_d;
      upd_leds_q  <= upd_leds_d;
      last_sent_q <= last_sent_d;
    end
  end

  assign upd_valid = (state_q == PEND);
  assign upd_leds  = upd_leds_q;

endmodule
